// File: rtl/branch_resolve_queue_pkg.sv
// branch_resolve_queue_pkg: shared address width and prediction-entry layout for the resolve queue.
package branch_resolve_queue_pkg;
  localparam int IM_ADDR_BIT = 10;
  localparam int ENTRY_W = 3 * IM_ADDR_BIT + 1;
  // Entry packs as {pc, pc_4, hit, guess}; offsets are in bits from the LSB.
  function automatic int entry_w(input int aw);
    return 3 * aw + 1;
  endfunction
  function automatic int hit_lsb(input int aw);
    return aw;
  endfunction
  function automatic int pc4_lsb(input int aw);
    return aw + 1;
  endfunction
  function automatic int pc_lsb(input int aw);
    return 2 * aw + 1;
  endfunction
endpackage

// File: rtl/branch_resolve_queue_fifo_mem.sv
// brq_fifo_mem: DEPTH x W prediction storage, one write port and a combinational head read (never cleared).
module brq_fifo_mem #(
  parameter int W = 31,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order FIFO of fetch predictions, resolved against execute to build table write-back and redirects.
// Optional statistics counters are enabled by defining BRQ_STATS_EN.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int ADDR_W = IM_ADDR_BIT,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_pc,
  input  logic [ADDR_W-1:0]        push_pc_4,
  input  logic                     push_hit,
  input  logic [ADDR_W-1:0]        push_guess,
  input  logic                     resolve,
  input  logic                     res_taken,
  input  logic [ADDR_W-1:0]        res_target,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     w_en,
  output logic                     succeed,
  output logic [ADDR_W-1:0]        pc_before_g,
  output logic [ADDR_W-1:0]        g_addr,
  output logic                     redirect,
  output logic [ADDR_W-1:0]        redirect_addr
`ifdef BRQ_STATS_EN
  ,
  output logic [15:0]              stat_resolved,
  output logic [15:0]              stat_mispred
`endif
);
  localparam int EW = entry_w(ADDR_W);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic [EW-1:0]     w_head;
  logic [ADDR_W-1:0] w_h_pc, w_h_pc4, w_h_guess, w_actual;
  logic              w_h_hit, w_res_ok, w_push_ok, w_mis, w_flush;

  brq_fifo_mem #(.W(EW), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .i_we    (w_push_ok & ~w_flush),
    .i_waddr (r_wr_ptr),
    .i_wdata ({push_pc, push_pc_4, push_hit, push_guess}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  assign w_h_pc    = w_head[pc_lsb(ADDR_W) +: ADDR_W];
  assign w_h_pc4   = w_head[pc4_lsb(ADDR_W) +: ADDR_W];
  assign w_h_hit   = w_head[hit_lsb(ADDR_W)];
  assign w_h_guess = w_head[ADDR_W-1:0];

  assign full      = r_count == CW'(DEPTH);
  assign empty     = r_count == '0;
  assign count     = r_count;
  assign w_res_ok  = en & resolve & ~empty;
  // A resolving slot frees space this cycle, so push is legal even when full.
  assign w_push_ok = en & push & (~full | w_res_ok);
  assign w_actual  = res_taken ? res_target : w_h_pc4;
  assign w_mis     = w_actual != w_h_guess;
  assign w_flush   = w_res_ok & w_mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      w_en          <= 1'b0;
      succeed       <= 1'b0;
      pc_before_g   <= '0;
      g_addr        <= '0;
      redirect      <= 1'b0;
      redirect_addr <= '0;
    end else begin
      w_en     <= 1'b0;
      redirect <= 1'b0;
      if (w_res_ok) begin
        w_en          <= w_h_hit | res_taken;
        succeed       <= res_taken;
        pc_before_g   <= w_h_pc;
        g_addr        <= res_target;
        redirect      <= w_mis;
        redirect_addr <= w_actual;
      end
      // Mispredict drops every younger entry, including a same-cycle wrong-path push.
      if (w_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_res_ok) r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + CW'(w_push_ok) - CW'(w_res_ok);
      end
    end
  end

`ifdef BRQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      if (w_res_ok && stat_resolved != 16'hFFFF) stat_resolved <= stat_resolved + 16'd1;
      if (w_flush && stat_mispred != 16'hFFFF) stat_mispred <= stat_mispred + 16'd1;
    end
  end
`endif
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Sits directly downstream of the branch history table.
- Captures every fetch-time prediction (PC, PC+4, hit, guessed next address) in an in-order FIFO until execute resolves that branch.
- On resolution, compares the actual next PC with the guess and produces the table write-back bundle (w_en, succeed, pc_before_g, g_addr).
- Raises a one-cycle redirect on mispredict and flushes all younger predictions.

Parameters:
ADDR_W, 10, instruction-memory address width; matches IM_ADDR_BIT.
DEPTH, 4, in-flight prediction entries; power of two, minimum 2.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
en  input  1  global pipeline enable; when 0 all state holds.
push  input  1  fetch issued a prediction this cycle.
push_pc  input  ADDR_W  PC of the predicted instruction.
push_pc_4  input  ADDR_W  PC+4 of that instruction.
push_hit  input  1  table hit flag at fetch.
push_guess  input  ADDR_W  guessed next PC at fetch.
resolve  input  1  execute resolves the oldest branch.
res_taken  input  1  actual branch outcome.
res_target  input  ADDR_W  computed branch target (valid even if not taken).
full  output  1  count == DEPTH.
empty  output  1  count == 0.
count  output  log2(DEPTH)+1  occupancy.
w_en  output  1  table write strobe, one-cycle pulse.
succeed  output  1  branch was taken.
pc_before_g  output  ADDR_W  tag to update.
g_addr  output  ADDR_W  target to store.
redirect  output  1  mispredict pulse.
redirect_addr  output  ADDR_W  correct next PC.

Behaviour:
- Reset: rd_ptr, wr_ptr and count = 0. All outputs 0, so empty = 1 and full = 0. Entry storage is not cleared.
- Storage: circular buffer of {pc, pc_4, hit, guess}. Pointers are log2(DEPTH) bits and wrap naturally. full and empty are combinational from count.
- When en = 0: no state change. w_en and redirect are registered to 0 that cycle. Data outputs hold.
- Push accepted when en & push & (!full | accepted resolve). A push while full with no resolve is dropped silently.
- Resolve accepted when en & resolve & !empty. A resolve while empty is ignored and produces no pulse.
- Resolve computation, on the head entry H:
  - actual = res_taken ? res_target : H.pc_4.
  - mis = (actual != H.guess).
- Registered outputs, one-cycle latency after an accepted resolve:
  - w_en <= H.hit | res_taken. Not-taken misses are never allocated.
  - succeed <= res_taken.
  - pc_before_g <= H.pc.
  - g_addr <= res_target.
  - redirect <= mis.
  - redirect_addr <= actual.
- Cycles with no accepted resolve: w_en and redirect <= 0; data outputs hold their previous values.
- Mispredict flush, same edge as the accepted resolve: rd_ptr, wr_ptr and count <= 0. Any simultaneous push is discarded as wrong-path.
- Resolve without mispredict plus push in the same cycle: both take effect and count is unchanged. This is legal even when full.
- Ordering: strictly in order; the head is always the oldest accepted push.
- Reset mid-operation: immediate clear. Any pending pulse is squashed asynchronously.

Optional Feature:
- Macro BRQ_STATS_EN.
- When defined:
  - Adds 16-bit output ports stat_resolved and stat_mispred.
  - stat_resolved increments on each accepted resolve; stat_mispred increments on each mispredict.
  - Both saturate at 16'hFFFF, reset to 0, and freeze while en = 0.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared core header: ADDR_W default (IM_ADDR_BIT) and the entry field layout widths. Add a localparam for the packed entry width (3*ADDR_W+1).
- One natural sub-module, brq_fifo_mem: DEPTH×entry register array with a write port and a combinational head read.

Test Plan:
- Reset with rst=1 mid-stream after 3 pushes -> count=0, empty=1, w_en=0, redirect=0 immediately (asynchronously).
- Push {pc=0x010, pc_4=0x014, hit=1, guess=0x040}; resolve taken, target 0x040 -> next cycle w_en=1, succeed=1, pc_before_g=0x010, g_addr=0x040, redirect=0, count=0.
- Push {pc=0x020, pc_4=0x024, hit=0, guess=0x024}; resolve not-taken, target 0x080 -> w_en=0, redirect=0. Repeat with taken -> w_en=1, redirect=1, redirect_addr=0x080.
- Fill 4 entries; 5th push alone is dropped, full=1. Then push+resolve (correct) together -> count stays 4, and pointers wrap correctly across 8 consecutive resolves in FIFO order.
- 3 entries queued; head mispredicts while push asserted -> redirect=1, count=0, pushed entry absent. A subsequent resolve with empty=1 gives no pulse.
- en=0 with push and resolve asserted -> no change in count or pointers, w_en=0. With BRQ_STATS_EN: 2 correct and 1 mispredicting resolve -> stat_resolved=3, stat_mispred=1.
